// File: rtl/axis_fifo_reader.sv
// Drains a first-word-fall-through FIFO into an AXI-Stream master with tlast every PKT_LEN beats.
// Latency 1 cycle from pop to tvalid; a two-entry out/skid stage keeps fifo_rd_en off the tready path.
module axis_fifo_reader #(
    parameter int WIDTH   = 24,
    parameter int PKT_LEN = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             pkt_done
);

    localparam int CW = $clog2(PKT_LEN) + 1;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_dat;
    logic             r_out_last;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_skid_dat;
    logic             r_skid_last;
    logic [CW-1:0]    r_beat_cnt;
    logic             r_pkt_done;

    logic             w_pop;
    logic             w_hs;
    logic             w_last;

    // Pop only while the skid is empty, so at most one word can arrive per stalled cycle.
    assign w_pop  = enable & ~fifo_empty & ~r_skid_vld;
    assign w_hs   = r_out_vld & m_axis_tready;
    assign w_last = (r_beat_cnt == CW'(PKT_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld   <= 1'b0;
            r_out_dat   <= '0;
            r_out_last  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_dat  <= '0;
            r_skid_last <= 1'b0;
            r_beat_cnt  <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_done <= w_hs & r_out_last;

            if (w_pop) begin
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + CW'(1);
            end

            if (r_skid_vld && w_hs) begin
                r_out_dat  <= r_skid_dat;
                r_out_last <= r_skid_last;
                r_skid_vld <= 1'b0;
            end else if (w_pop && (!r_out_vld || w_hs)) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= fifo_dout;
                r_out_last <= w_last;
            end else if (w_pop && r_out_vld && !w_hs) begin
                r_skid_vld  <= 1'b1;
                r_skid_dat  <= fifo_dout;
                r_skid_last <= w_last;
            end else if (w_hs && !r_skid_vld) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign fifo_rd_en    = w_pop;
    assign m_axis_tdata  = r_out_dat;
    assign m_axis_tvalid = r_out_vld;
    assign m_axis_tlast  = r_out_last;
    assign pkt_done      = r_pkt_done;

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Bench for axis_fifo_reader: three instances (PKT_LEN 4, 7, 1) share one FIFO/sink model.
// Expected behaviour comes from an occupancy/queue model, not from the RTL structure.
module tb_axis_fifo_reader;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [W-1:0]  fifo_dout;
    logic          fifo_empty;
    logic          tready;

    logic          rd_en  [3];
    logic [W-1:0]  tdata  [3];
    logic          tvalid [3];
    logic          tlast  [3];
    logic          done   [3];

    always #5 clk = ~clk;

    axis_fifo_reader #(.WIDTH(W), .PKT_LEN(4)) u_p4 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en[0]), .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]),
        .m_axis_tready(tready), .m_axis_tlast(tlast[0]), .pkt_done(done[0]));

    axis_fifo_reader #(.WIDTH(W), .PKT_LEN(7)) u_p7 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en[1]), .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]),
        .m_axis_tready(tready), .m_axis_tlast(tlast[1]), .pkt_done(done[1]));

    axis_fifo_reader #(.WIDTH(W), .PKT_LEN(1)) u_p1 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en[2]), .m_axis_tdata(tdata[2]), .m_axis_tvalid(tvalid[2]),
        .m_axis_tready(tready), .m_axis_tlast(tlast[2]), .pkt_done(done[2]));

    // Reference model: upstream FIFO contents, words popped but not yet accepted, beat index since reset.
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           hs_cnt;
    bit   [2:0]   exp_done;
    bit           gap;
    int           obs_pops;
    int           obs_hs;
    int           obs_done [3];
    int           obs_last [3];
    int           n_checks = 0;
    int           n_errors = 0;

    function automatic int plen(input int i);
        case (i)
            0:       return 4;
            1:       return 7;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = gap || (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge, return #1 later.
    task automatic cycle();
        bit       pop;
        bit       hs;
        bit [2:0] nd;
        bit       lst;
        nd = '0;
        @(negedge clk);
        pop = enable && !fifo_empty && (exp_q.size() < 2);
        hs  = (exp_q.size() > 0) && tready;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                lst = ((hs_cnt % plen(i)) == plen(i) - 1);
                chk($sformatf("rd_en[%0d]", i), rd_en[i], pop);
                chk($sformatf("tvalid[%0d]", i), tvalid[i], exp_q.size() > 0);
                chk($sformatf("pkt_done[%0d]", i), done[i], exp_done[i]);
                if (exp_q.size() > 0) begin
                    chk($sformatf("tdata[%0d]", i), tdata[i], exp_q[0]);
                    chk($sformatf("tlast[%0d]", i), tlast[i], lst);
                end
                nd[i] = hs && lst;
                if (done[i]) obs_done[i]++;
                if (tvalid[i] && tready && tlast[i]) obs_last[i]++;
            end
            if (rd_en[0]) obs_pops++;
            if (tvalid[0] && tready) obs_hs++;
        end
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            fifo_q.delete();
            hs_cnt   = 0;
            exp_done = '0;
        end else begin
            if (hs) begin
                void'(exp_q.pop_front());
                hs_cnt++;
            end
            if (pop) exp_q.push_back(fifo_q.pop_front());
            exp_done = nd;
        end
        #1;
        drive_fifo();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'(n), 32'(budget - 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, h0, pushed;
        int d0 [3];
        int l0 [3];
        reset    = 1'b1;
        enable   = 1'b0;
        tready   = 1'b0;
        gap      = 1'b0;
        hs_cnt   = 0;
        exp_done = '0;
        obs_pops = 0;
        obs_hs   = 0;
        for (int i = 0; i < 3; i++) begin
            obs_done[i] = 0;
            obs_last[i] = 0;
        end
        drive_fifo();

        // Reset values
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("rst_tvalid", tvalid[i], 0);
            chk("rst_tdata", tdata[i], 0);
            chk("rst_tlast", tlast[i], 0);
            chk("rst_pkt_done", done[i], 0);
            chk("rst_rd_en", rd_en[i], 0);
        end

        // Single word
        enable = 1'b1;
        tready = 1'b1;
        p0 = obs_pops;
        push(24'hA5A5A5);
        drain(20, n);
        cycle();
        chk("single_pops", obs_pops - p0, 1);
        chk("single_cycles", n, 2);
        chk("single_tvalid_after", tvalid[0], 0);

        // Streaming 8 words
        do_reset();
        for (int k = 1; k <= 8; k++) push(W'(k));
        enable = 1'b1;
        tready = 1'b1;
        for (int i = 0; i < 3; i++) d0[i] = obs_done[i];
        drain(40, n);
        cycle();
        cycle();
        chk("stream_cycles", n, 9);
        chk("stream_done_p4", obs_done[0] - d0[0], 2);
        chk("stream_done_p7", obs_done[1] - d0[1], 1);
        chk("stream_done_p1", obs_done[2] - d0[2], 8);

        // Backpressure: 5 stalled cycles absorb exactly out + skid
        do_reset();
        for (int k = 1; k <= 6; k++) push(W'(k));
        enable = 1'b1;
        tready = 1'b0;
        p0 = obs_pops;
        repeat (5) cycle();
        chk("stall_pops", obs_pops - p0, 2);
        chk("stall_tdata", tdata[0], 1);
        chk("stall_tvalid", tvalid[0], 1);
        tready = 1'b1;
        drain(40, n);
        chk("release_cycles", n, 6);

        // Random tready, FIFO gaps and enable over 1000 words
        do_reset();
        pushed = 0;
        n      = 0;
        h0     = obs_hs;
        for (int i = 0; i < 3; i++) d0[i] = obs_done[i];
        while ((pushed < 1000 || exp_q.size() > 0 || fifo_q.size() > 0) && n < 20000) begin
            if (pushed < 1000 && fifo_q.size() < 6 && $urandom_range(0, 1) == 1) begin
                fifo_q.push_back(W'($urandom));
                pushed++;
            end
            tready = ($urandom_range(0, 1) == 1);
            gap    = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 9) != 0);
            drive_fifo();
            cycle();
            n++;
        end
        gap    = 1'b0;
        enable = 1'b1;
        tready = 1'b1;
        drive_fifo();
        cycle();
        cycle();
        chk("random_no_timeout", (n < 20000), 1);
        chk("random_beats", obs_hs - h0, 1000);
        chk("random_done_p4", obs_done[0] - d0[0], 250);
        chk("random_done_p7", obs_done[1] - d0[1], 142);
        chk("random_done_p1", obs_done[2] - d0[2], 1000);

        // PKT_LEN = 1: every beat is last
        do_reset();
        enable = 1'b1;
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d0[i] = obs_done[i];
            l0[i] = obs_last[i];
        end
        for (int k = 0; k < 3; k++) push(W'(24'h300 + k));
        drain(20, n);
        cycle();
        chk("p1_last_beats", obs_last[2] - l0[2], 3);
        chk("p1_done", obs_done[2] - d0[2], 3);

        // Reset mid-packet with out and skid full
        do_reset();
        for (int k = 1; k <= 6; k++) push(W'(24'h100 + k));
        enable = 1'b1;
        tready = 1'b1;
        n = 0;
        while (hs_cnt < 2 && n < 20) begin
            cycle();
            n++;
        end
        tready = 1'b0;
        n = 0;
        while (exp_q.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("pre_reset_tvalid", tvalid[0], 1);
        chk("pre_reset_full", rd_en[0], 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("post_reset_tvalid", tvalid[0], 0);
        chk("post_reset_pkt_done", done[0], 0);
        for (int i = 0; i < 3; i++) l0[i] = obs_last[i];
        for (int k = 1; k <= 4; k++) push(W'(24'h200 + k));
        tready = 1'b1;
        drain(20, n);
        cycle();
        chk("fresh_last_p4", obs_last[0] - l0[0], 1);
        chk("fresh_last_p7", obs_last[1] - l0[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_fifo_reader.md
# axis_fifo_reader

Drains a first-word-fall-through FIFO read port and presents the words as an AXI-Stream master with packet framing. Sits downstream of the stream FIFO. Pops one word per cycle while space allows, carries each word through a two-entry output/skid stage, and asserts tlast on every PKT_LEN-th beat. Keeps the FIFO pop decision off the combinational tready path.

## Interface
- WIDTH, 24, data width; must match the FIFO word width
- PKT_LEN, 256, beats per packet (≥1); tlast marks the last beat of each packet
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- enable  input  1  permits new pops from the FIFO; stages already holding data still drain when low
- fifo_dout  input  WIDTH  FIFO head word, valid whenever fifo_empty=0
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  pop strobe to FIFO; head advances at the clock edge where it is high
- m_axis_tdata  output  WIDTH  stream data
- m_axis_tvalid  output  1  stream valid
- m_axis_tready  input  1  stream ready from sink
- m_axis_tlast  output  1  last beat of packet
- pkt_done  output  1  one-cycle pulse, registered, the cycle after a tlast beat handshakes

## Operation
- Two registered entries: out (out_valid, out_data, out_last) drives m_axis_*; skid (skid_valid, skid_data, skid_last) holds overflow.
- pop = enable & !fifo_empty & !skid_valid; fifo_rd_en = pop. It depends only on registered state, enable and fifo_empty, never on tready.
- Handshake hs = out_valid & m_axis_tready.
- Beat counter beat_cnt, width $clog2(PKT_LEN)+1, counts popped words 0..PKT_LEN-1. The popped word's last tag = (beat_cnt == PKT_LEN-1). On pop, beat_cnt wraps to 0 after PKT_LEN-1, otherwise increments. With PKT_LEN=1, every word is tagged last.
- Per clock, priority in this order:
  - skid_valid & hs: out ← skid, skid_valid ← 0. No pop is possible this cycle.
  - pop & (!out_valid | hs): out ← popped word, out_valid ← 1.
  - pop & out_valid & !hs: skid ← popped word, skid_valid ← 1.
  - no pop & hs & !skid_valid: out_valid ← 0.
- pkt_done ← hs & out_last.
- Word order is strictly preserved. No word is dropped or duplicated.
- Reset mid-packet clears out_valid, skid_valid, beat_cnt and pkt_done. Words already popped are discarded, and the next packet restarts at beat 0. The upstream FIFO is expected to be reset together with this block.

## Timing
- Reset values: fifo_rd_en=0 (combinational; 0 while skid empty only if enable=0 or FIFO empty), m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pkt_done=0, beat_cnt=0.
- Latency: a word popped at edge N is on m_axis_tdata with tvalid=1 after edge N.
- Throughput: 1 beat/cycle sustained while tready=1 and the FIFO is non-empty.
- AXI rule: once tvalid=1, tdata and tlast stay stable and tvalid stays high until hs. tvalid does not depend on tready.
- Backpressure: the first stalled cycle absorbs at most one extra word into skid, then fifo_rd_en=0 until skid drains.
- enable falling edge: pops stop the same cycle. Up to two buffered words still drain. beat_cnt is held, so the packet resumes mid-count on re-enable.
- FIFO empty while a packet is in progress: tvalid drops after the last buffered word. No tlast is inserted.

## Test plan
- Single word: PKT_LEN=4, push 0xA5A5A5, tready=1 → fifo_rd_en high 1 cycle; tvalid=1 with tdata=0xA5A5A5, tlast=0 the next cycle, then tvalid=0.
- Streaming: PKT_LEN=4, 8 words 1..8, tready=1 → 8 consecutive beats; tlast on words 4 and 8; pkt_done pulses the cycle after each of those beats.
- Backpressure: 6 words, tready=0 for 5 cycles then 1 → exactly 2 words popped during the stall (out+skid); tdata stays 1 throughout the stall; output order 1..6 with no gaps after release.
- Random tready (50%) and random fifo_empty gaps over 1000 words, PKT_LEN=7 → scoreboard matches exactly; tlast on every 7th beat; tvalid never drops without a handshake.
- PKT_LEN=1: 3 words → tlast=1 on all 3 beats; 3 pkt_done pulses.
- Reset mid-packet: PKT_LEN=4, reset after beat 2 handshakes with out and skid full → tvalid=0 the cycle after reset; the next 4 fresh words give tlast only on the 4th.
